por_reset_sequencer: RTL and testbench

//  Digital consumer of the Schmitt-buffered power-good level.

---
 rtl/por_reset_sequencer_pkg.sv | 18 +
 rtl/por_reset_sequencer_debounce.sv | 66 ++++++
 rtl/por_reset_sequencer.sv | 114 +++++++++++
 tb/tb_por_reset_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/por_reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// por_reset_sequencer_pkg
//   Shared constants for the power-on reset sequencer: the FSM state
//   encoding (also visible on the top-level state port) and the
//   saturation value of the glitch counter.
// ---------------------------------------------------------------------------
package por_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RESET_HOLD  = 2'd0,
        ST_WAIT_STABLE = 2'd1,
        ST_RELEASE_H   = 2'd2,
        ST_RUN         = 2'd3
    } por_state_t;

    localparam logic [7:0] GLITCH_MAX = 8'hFF;

endpackage

// File: rtl/por_reset_sequencer_debounce.sv
// ---------------------------------------------------------------------------
// por_debounce
//   Synchronises the asynchronous Schmitt output and debounces it. The
//   debounced level only flips after the synchronised level has differed
//   from it for DEBOUNCE_CYCLES consecutive cycles. Every attempt that is
//   abandoned before reaching that count bumps a saturating glitch counter.
//
// Ports
//   clk         in   system clock
//   resetb      in   asynchronous active-low reset
//   din         in   asynchronous level to be filtered
//   deb         out  debounced level
//   glitch_cnt  out  saturating count of aborted debounce attempts
// ---------------------------------------------------------------------------
module por_debounce
    import por_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       din,
    output logic       deb,
    output logic [7:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic [CNT_W-1:0]       dcnt;

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dcnt       <= '0;
            deb        <= 1'b0;
            glitch_cnt <= '0;
        end else if (sync_q != deb) begin
            if (dcnt == DCNT_LAST) begin
                deb  <= sync_q;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end else begin
            // Level fell back before the count completed: a glitch.
            dcnt <= '0;
            if (dcnt != '0 && glitch_cnt != GLITCH_MAX) begin
                glitch_cnt <= glitch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/por_reset_sequencer.sv
// ---------------------------------------------------------------------------
// por_reset_sequencer
//   Consumes the Schmitt-buffered power-good level. After the debounced
//   level has been high for HOLD_CYCLES it releases porb_h, then after
//   STAGE_GAP more cycles releases porb_l / por_l. Loss of power-good or a
//   software force_reset re-asserts every reset on the next edge.
//
// Ports
//   clk          in   system clock
//   resetb       in   asynchronous active-low reset
//   schmitt_in   in   Schmitt buffer output, asynchronous to clk
//   force_reset  in   synchronous software hold request, active-high
//   porb_h       out  first-stage reset, active-low
//   porb_l       out  second-stage reset, active-low
//   por_l        out  inverse of porb_l, active-high
//   rst_done     out  high only in RUN
//   state        out  current FSM state encoding
//   glitch_cnt   out  saturating count of aborted debounce attempts
// ---------------------------------------------------------------------------
module por_reset_sequencer
    import por_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int STAGE_GAP       = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       schmitt_in,
    input  logic       force_reset,
    output logic       porb_h,
    output logic       porb_l,
    output logic       por_l,
    output logic       rst_done,
    output logic [1:0] state,
    output logic [7:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    logic             deb;
    logic [CNT_W-1:0] timer;
    por_state_t       st;

    assign state = st;

    por_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk        (clk),
        .resetb     (resetb),
        .din        (schmitt_in),
        .deb        (deb),
        .glitch_cnt (glitch_cnt)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            st       <= ST_RESET_HOLD;
            timer    <= '0;
            porb_h   <= 1'b0;
            porb_l   <= 1'b0;
            por_l    <= 1'b1;
            rst_done <= 1'b0;
        end else if (!deb || force_reset) begin
            // Abort outranks every timer transition, from any state.
            st       <= ST_RESET_HOLD;
            timer    <= '0;
            porb_h   <= 1'b0;
            porb_l   <= 1'b0;
            por_l    <= 1'b1;
            rst_done <= 1'b0;
        end else begin
            unique case (st)
                ST_RESET_HOLD: begin
                    st    <= ST_WAIT_STABLE;
                    timer <= '0;
                end
                ST_WAIT_STABLE: begin
                    if (timer == HOLD_LAST) begin
                        st     <= ST_RELEASE_H;
                        porb_h <= 1'b1;
                        timer  <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RELEASE_H: begin
                    if (timer == GAP_LAST) begin
                        st       <= ST_RUN;
                        porb_l   <= 1'b1;
                        por_l    <= 1'b0;
                        rst_done <= 1'b1;
                        timer    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RUN: begin
                    st <= ST_RUN;
                end
                default: begin
                    st <= ST_RESET_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_por_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_por_reset_sequencer
//   Directed bench for por_reset_sequencer with SYNC=2, DEBOUNCE=4, HOLD=8,
//   GAP=2. Expected output vectors are queued when stimulus is applied and
//   popped for comparison once the DUT has had time to respond.
// ---------------------------------------------------------------------------
module tb_por_reset_sequencer;

    logic       clk = 1'b0;
    logic       resetb;
    logic       schmitt_in;
    logic       force_reset;
    logic       porb_h;
    logic       porb_l;
    logic       por_l;
    logic       rst_done;
    logic [1:0] state;
    logic [7:0] glitch_cnt;

    always #5 clk = ~clk;

    por_reset_sequencer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .STAGE_GAP       (2),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .schmitt_in  (schmitt_in),
        .force_reset (force_reset),
        .porb_h      (porb_h),
        .porb_l      (porb_l),
        .por_l       (por_l),
        .rst_done    (rst_done),
        .state       (state),
        .glitch_cnt  (glitch_cnt)
    );

    // Output vector layout: {porb_h, porb_l, por_l, rst_done, state, glitch_cnt}
    localparam logic [13:0] MASK_ALL  = 14'h3FFF;
    localparam logic [13:0] MASK_NOGL = 14'h3F00;

    typedef struct {
        string       tag;
        logic [13:0] exp;
        logic [13:0] mask;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [13:0] mk(input logic h, input logic l, input logic pl,
                                       input logic d, input logic [1:0] st,
                                       input logic [7:0] g);
        return {h, l, pl, d, st, g};
    endfunction

    // Expected vector e edges after the first sampled 1, from RESET_HOLD.
    function automatic logic [13:0] rise_vec(input int e, input logic [7:0] g);
        if (e < 7)       return mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, g);
        else if (e < 15) return mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, g);
        else if (e < 17) return mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, g);
        else             return mk(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, g);
    endfunction

    task automatic push_exp(input string tag, input logic [13:0] exp, input logic [13:0] mask);
        exp_t x;
        x.tag  = tag;
        x.exp  = exp;
        x.mask = mask;
        expq.push_back(x);
    endtask

    task automatic check_out();
        exp_t        x;
        logic [13:0] obs;
        obs = {porb_h, porb_l, por_l, rst_done, state, glitch_cnt};
        vectors++;
        if (expq.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h required a queued entry", obs);
        end else begin
            x = expq.pop_front();
            assert ((obs & x.mask) === (x.exp & x.mask)) else begin
                miscompares++;
                $error("FAIL %s: observed %h required %h (mask %h)", x.tag, obs, x.exp, x.mask);
            end
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] gexp;

    initial begin
        resetb      = 1'b0;
        schmitt_in  = 1'b0;
        force_reset = 1'b0;
        gexp        = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        push_exp("reset_state", mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0), MASK_ALL);
        check_out();

        // 1. Power-up: schmitt_in=1 sampled from edge 1
        resetb     = 1'b1;
        schmitt_in = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            push_exp($sformatf("powerup_e%0d", e), rise_vec(e, gexp), MASK_ALL);
            next_edge();
            check_out();
        end

        // 2. Two-cycle low glitch in RUN: outputs hold, glitch_cnt +1
        schmitt_in = 1'b0;
        repeat (2) begin
            push_exp("glitch_run_hold", mk(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd0), MASK_NOGL);
            next_edge();
            check_out();
        end
        schmitt_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_exp("glitch_run_hold", mk(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd0), MASK_NOGL);
            next_edge();
            check_out();
        end
        gexp = 8'd1;
        push_exp("glitch_run_cnt", mk(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, gexp), MASK_ALL);
        check_out();

        // 3. Sustained low in RUN: resets assert at edge 7
        schmitt_in = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            if (e < 7)
                push_exp($sformatf("fall_e%0d", e), mk(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, gexp), MASK_ALL);
            else
                push_exp("fall_e7", mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, gexp), MASK_ALL);
            next_edge();
            check_out();
        end

        // 4. Rise again to RELEASE_H (edge 15), then force_reset for one cycle
        schmitt_in = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            push_exp($sformatf("rerise_e%0d", e), rise_vec(e, gexp), MASK_ALL);
            next_edge();
            check_out();
        end
        force_reset = 1'b1;
        push_exp("force_abort", mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, gexp), MASK_ALL);
        next_edge();
        check_out();
        force_reset = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            // Dropping force_reset with deb=1 behaves like edge 7 of a rise.
            push_exp($sformatf("force_drop_e%0d", e), rise_vec(e + 6, gexp), MASK_ALL);
            next_edge();
            check_out();
        end

        // 5. Async reset mid-WAIT_STABLE
        force_reset = 1'b1;
        next_edge();
        force_reset = 1'b0;
        repeat (3) next_edge();
        push_exp("wait_stable_pre", mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, gexp), MASK_ALL);
        check_out();
        @(posedge clk);
        #2;
        resetb = 1'b0;
        #1;
        gexp = 8'd0;
        push_exp("async_reset", mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, gexp), MASK_ALL);
        check_out();
        @(negedge clk);
        schmitt_in = 1'b0;
        resetb     = 1'b1;
        next_edge();

        // 6. 300 two-cycle high glitches while deb=0: glitch_cnt saturates
        for (int i = 1; i <= 300; i++) begin
            schmitt_in = 1'b1;
            repeat (2) next_edge();
            schmitt_in = 1'b0;
            repeat (4) next_edge();
            if (gexp != 8'hFF) gexp = gexp + 8'd1;
            push_exp($sformatf("glitch_sat_%0d", i), mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, gexp), MASK_ALL);
            check_out();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
